// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: initiator-side controller between the MEM stage and a
// word-addressed data memory. Handles byte/half/word loads and stores over a
// valid/ready handshake, performs sub-word stores as read-modify-write,
// extends sub-word loads, and answers misaligned or illegal-size requests
// with an error response without touching memory.
module dm_access_ctrl #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    // Request fields captured at accept; only the low half of store data is
    // needed because full-word store data goes straight into mem_wdata.
    logic        wr_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        accept;
    logic        bad;
    logic        word_store;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    logic              mem_en_d;
    logic              mem_we_d;
    logic [ADDR_W-3:0] mem_addr_d;
    logic [31:0]       mem_wdata_d;
    logic              resp_valid_d;
    logic [31:0]       resp_rdata_d;
    logic              resp_err_d;

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // Classify the incoming request: alignment / size legality and word store.
    always_comb begin
        bad = 1'b0;
        case (req_size)
            2'b01:   bad = req_addr[0];
            2'b10:   bad = (req_addr[1:0] != 2'b00);
            2'b11:   bad = 1'b1;
            default: bad = 1'b0;
        endcase
        word_store = req_write && (req_size == 2'b10) && !bad;
    end

    // Extract and extend the load lane, and build the read-modify-write word.
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (size_q)
            2'b00:   load_data = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_data = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_data = mem_rdata;
        endcase

        merge_data = mem_rdata;
        if (size_q == 2'b00) begin
            case (lane_q)
                2'd0:    merge_data[7:0]   = wdata_q[7:0];
                2'd1:    merge_data[15:8]  = wdata_q[7:0];
                2'd2:    merge_data[23:16] = wdata_q[7:0];
                default: merge_data[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merge_data[31:16] = wdata_q;
        end else begin
            merge_data[15:0] = wdata_q;
        end
    end

    // State register plus registered outputs and captured request fields.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            wr_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= '0;
            lane_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= next_state;
            mem_en     <= mem_en_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
            if (accept) begin
                wr_q    <= req_write;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                lane_q  <= req_addr[1:0];
                wdata_q <= req_wdata[15:0];
            end
        end
    end

    // Next-state logic for the request sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad)             next_state = RESP;
                    else if (word_store) next_state = WR;
                    else                 next_state = RD;
                end
            end
            RD:   next_state = CAP;
            CAP:  next_state = wr_q ? WR : RESP;
            WR:   next_state = RESP;
            RESP: if (resp_valid && resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so strobes and resp_valid
    // line up with the state they belong to.
    always_comb begin
        mem_en_d     = (next_state == RD) || (next_state == WR);
        mem_we_d     = (next_state == WR);
        resp_valid_d = (next_state == RESP);
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;
        if (accept) begin
            mem_addr_d   = req_addr[ADDR_W-1:2];
            resp_rdata_d = '0;
            resp_err_d   = bad;
            if (word_store) mem_wdata_d = req_wdata;
        end
        if (state == CAP) begin
            if (wr_q) mem_wdata_d  = merge_data;
            else      resp_rdata_d = load_data;
        end
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Initiator-side memory access controller between the CPU MEM stage and the word-addressed data memory.
- Accepts byte, halfword and word load/store requests on a valid/ready handshake.
- Performs sub-word stores as read-modify-write; sign- or zero-extends sub-word loads.
- Detects misaligned accesses and answers them with an error response without touching memory.

Parameters:
ADDR_W, 14, byte-address width; memory word address is ADDR_W-2 bits (4096 words at default)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request (high only in IDLE)
req_write  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1=zero-extend, 0=sign-extend
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned (sub-word data in low bits)
resp_valid  output  1  response present; held until resp_ready
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned or illegal-size request
mem_en  output  1  memory access strobe
mem_we  output  1  write when mem_en=1
mem_addr  output  ADDR_W-2  word address
mem_wdata  output  32  full word to write
mem_rdata  input  32  read data, valid exactly one cycle after a read strobe (mem_en=1, mem_we=0)

Behaviour:
- Reset is synchronous, active-high, clock clk. Reset values:
  - state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0
  - req_ready=1 from the first cycle after reset
- All outputs except req_ready are registered. req_ready = (state==IDLE) && !reset.
- Accept on a rising edge with req_valid && req_ready; capture write, size, unsigned, addr, wdata. No request is accepted in any other state.
- Byte lanes are little-endian: byte k (addr[1:0]=k) is bits [8k+7:8k]; the half at addr[1]=h is bits [16h+15:16h].
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=00.
  - size 11 is always illegal.
  - A violation goes straight to RESP with resp_err=1 and resp_rdata=0; mem_en is never asserted for that request.
- States: IDLE, RD, CAP, WR, RESP.
  - IDLE -> WR (word store), RD (load or sub-word store), RESP (error).
  - RD: mem_en=1, mem_we=0 for one cycle -> CAP.
  - CAP: sample mem_rdata.
    - Load: resp_rdata = extracted lane, sign- or zero-extended -> RESP.
    - Sub-word store: mem_wdata = read word with the target lane replaced by req_wdata low bits; other lanes unchanged -> WR.
  - WR: mem_en=1, mem_we=1 for exactly one cycle -> RESP.
  - RESP: resp_valid=1 and hold; on resp_valid && resp_ready -> IDLE, resp_valid=0 on the next cycle.
- mem_en is high only in RD and WR, always for exactly one cycle per visit. mem_addr = captured addr[ADDR_W-1:2] throughout the request.
- Latency from accept edge T, with resp_ready tied high:
  - error: resp_valid at T+1
  - word store: write at T+1, resp_valid at T+2
  - load: read at T+1, resp_valid at T+3
  - sub-word store: read at T+1, write at T+3, resp_valid at T+4
- Back-to-back: a new request can be accepted the cycle after the response handshake (earliest one cycle after resp_valid falls).
- Reset mid-operation: abandon the request immediately. No memory write may occur in the cycle after reset is sampled. Any pending response is dropped.
- req_* inputs are ignored outside IDLE; changing them mid-request has no effect.

Test Plan:
- Word round trip: store word 0xDEADBEEF to addr 0x0010, then load word from 0x0010 -> one write (mem_addr=0x004, wdata 0xDEADBEEF), resp_rdata=0xDEADBEEF, resp_err=0, latencies 2 and 3 cycles.
- Byte store RMW: memory word 4 = 0x11223344; store byte 0xAB to addr 0x0012 -> read then write 0x11AB3344; untouched lanes intact; resp_valid at T+4.
- Signed/unsigned loads: word 0x80F0_7F81 at addr 0x20:
  - lb 0x20 -> 0xFFFFFF81; lbu 0x20 -> 0x00000081
  - lh 0x22 -> 0xFFFF80F0; lhu 0x22 -> 0x000080F0
- Misalignment: lh at 0x0013, lw at 0x0016, size 11 at 0x0000 -> resp_err=1 at T+1, resp_rdata=0, mem_en never asserted.
- Backpressure: load with resp_ready held low 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout; accept of the next request only after the handshake.
- Reset mid-RMW: assert reset while in CAP of a byte store -> no write strobe afterwards, all outputs at reset values, req_ready=1 the next cycle, and the following request completes correctly.
